// File: rtl/bit_packer_128_if.sv
// rtl/bit_packer_128_if.sv - byte-stream input and mapper handover signals of bit_packer_128
interface bit_packer_128_if;
   logic [7:0]   din;
   logic         din_valid;
   logic         din_ready;
   logic         flush;
   logic         reader_en;
   logic [127:0] reader_data;
   logic         valid_o;
   logic [4:0]   fill_level;

   modport master (
      output din, din_valid, flush, reader_en,
      input  din_ready, reader_data, valid_o, fill_level
   );

   modport slave (
      input  din, din_valid, flush, reader_en,
      output din_ready, reader_data, valid_o, fill_level
   );
endinterface

// File: rtl/bit_packer_128.sv
// rtl/bit_packer_128.sv - packs a byte stream little-endian into 128-bit words for the BPSK mapper
// Optional PN9 energy-dispersal scrambler compiled in with BIT_PACKER_SCRAMBLE_EN.
module bit_packer_128 (
   input  logic             CLK,
   input  logic             RST,
   input  logic             ce,
   bit_packer_128_if.slave  bus
);
   typedef enum logic {FILL, HOLD} state_t;

   state_t       state;
   logic [127:0] word_buf;
   logic [127:0] reader_data_q;
   logic         valid_q;
   logic [4:0]   level;
   logic         accept;
   logic         close_word;
   logic [7:0]   byte_in;

   assign accept     = ce & bus.din_valid & (state == FILL);
   // A flush only closes a word that holds, or is about to hold, at least one byte.
   assign close_word = accept & (level == 5'd15) |
                       bus.flush & ((level != 5'd0) | accept);

`ifdef BIT_PACKER_SCRAMBLE_EN
   localparam logic [8:0] PN9_SEED = 9'h1FF;

   logic [8:0] lfsr;
   logic [8:0] lfsr_next;
   logic       flushed;

   // Fibonacci PN9 (x^9+x^5+1), LSB first: output is lfsr[0] before each shift.
   function automatic logic [16:0] pn9_byte(input logic [7:0] d, input logic [8:0] s);
      logic [7:0] o;
      logic [8:0] r;
      r = s;
      for (int i = 0; i < 8; i++) begin
         o[i] = d[i] ^ r[0];
         r    = {r[0] ^ r[5], r[8:1]};
      end
      return {r, o};
   endfunction

   assign {lfsr_next, byte_in} = pn9_byte(bus.din, lfsr);
`else
   assign byte_in = bus.din;
`endif

   always_ff @(posedge CLK) begin
      if (RST) begin
         state         <= FILL;
         word_buf      <= '0;
         reader_data_q <= '0;
         valid_q       <= 1'b0;
         level         <= 5'd0;
`ifdef BIT_PACKER_SCRAMBLE_EN
         lfsr          <= PN9_SEED;
         flushed       <= 1'b0;
`endif
      end else begin
         valid_q <= 1'b0;
         if (ce) begin
            case (state)
               FILL: begin
                  if (accept) begin
                     word_buf[{level[3:0], 3'b000} +: 8] <= byte_in;
`ifdef BIT_PACKER_SCRAMBLE_EN
                     lfsr <= lfsr_next;
`endif
                  end
                  // Unfilled bytes are already zero since the buffer clears on every emit.
                  if (close_word) begin
                     state <= HOLD;
                     level <= 5'd16;
`ifdef BIT_PACKER_SCRAMBLE_EN
                     flushed <= bus.flush;
`endif
                  end else if (accept) begin
                     level <= level + 5'd1;
                  end
               end
               HOLD: begin
                  if (bus.reader_en) begin
                     reader_data_q <= word_buf;
                     valid_q       <= 1'b1;
                     word_buf      <= '0;
                     level         <= 5'd0;
                     state         <= FILL;
`ifdef BIT_PACKER_SCRAMBLE_EN
                     if (flushed) begin
                        lfsr <= PN9_SEED;
                     end
                     flushed <= 1'b0;
`endif
                  end
               end
               default: state <= FILL;
            endcase
         end
      end
   end

   assign bus.din_ready   = (state == FILL);
   assign bus.reader_data = reader_data_q;
   assign bus.valid_o     = valid_q;
   assign bus.fill_level  = level;
endmodule

// File: doc/bit_packer_128.md
# bit_packer_128

Upstream feeder for the BPSK IQ mapper: collects a byte stream from the one-seg payload reader into 128-bit words and hands each word to the mapper. The mapper consumes `reader_data` LSB first (bit 0 is the first symbol), so bytes are packed little-endian. Handover uses the mapper's `reader_en` (idle/ready) flag and a one-cycle `valid_o` pulse. An optional PN9 energy-dispersal scrambler is compiled in by macro.

## Interface
- No parameters. Word width is fixed at 128 bits (16 bytes).
- Reset is synchronous and active-high.

- `CLK`  input  1  system clock; all logic on the rising edge.
- `RST`  input  1  synchronous, active-high reset.
- `ce`  input  1  clock enable. When low, all state holds.
- `din`  input  8  payload byte; bit 0 is transmitted first.
- `din_valid`  input  1  `din` is valid this cycle.
- `din_ready`  output  1  block accepts a byte this cycle. Equals `state==FILL`.
- `flush`  input  1  close the current partial word, zero-padded.
- `reader_en`  input  1  mapper is idle and can take a new word (mapper output).
- `reader_data`  output  128  packed word to the mapper; holds its value between emits.
- `valid_o`  output  1  one-cycle pulse; `reader_data` is new (drives mapper `valid_i`).
- `fill_level`  output  5  bytes currently held, 0..16.

## Operation
- Byte accept: `ce & din_valid & din_ready`.
- Byte k of a word (k = 0..15) goes to `buf[8k+7:8k]`.
- State machine:
  - **FILL**
    - Accepts bytes.
    - On the 16th accepted byte, go to HOLD.
    - If `flush=1` and `fill_level>0`: go to HOLD. Unfilled bytes are zero.
    - If a byte is accepted in the same cycle as `flush`, the byte is stored first, then padding is applied.
    - `flush` with `fill_level==0` and no byte accepted is ignored.
  - **HOLD**
    - `din_ready=0`; `flush` is ignored.
    - When `ce & reader_en`: load `reader_data <= buf`, pulse `valid_o`, clear `buf` and `fill_level`, go to FILL.
- `fill_level` reads 16 throughout HOLD, including the flushed case.
- `valid_o` is never high for more than one cycle. `reader_data` changes only on an emit edge.
- Reset values:
  - state FILL
  - `buf`, `reader_data` = 0
  - `valid_o` = 0
  - `fill_level` = 0
  - `din_ready` = 1
  - scrambler LFSR = seed
- Reset mid-word discards the partial word; no emit occurs.
- `ce` low:
  - No accept, no transition, no emit.
  - `valid_o` is driven 0.
  - `din_ready` still reflects the state, but no accept occurs while `ce` is low.

## Timing
- Accepted byte → `fill_level` increments at the same edge.
- 16th byte accepted at edge N → HOLD from N. If `reader_en=1` at edge N+1, `valid_o` is high in the cycle after N+1.
- Flush at edge N → same timing as the 16th byte.
- Minimum spacing between emits is 17 cycles. This guarantees the mapper has deasserted `reader_en` after its `valid_i`.
- `reader_en` is sampled only in HOLD. Its level while in FILL is ignored.
- No combinational path from `reader_en` or `din_valid` to any output.

## Configuration
- `BIT_PACKER_SCRAMBLE_EN`
  - **Defined:**
    - Each payload bit is XORed with a PN9 sequence (x^9+x^5+1, seed 9'h1FF). Processing order is LSB first within a byte.
    - Output bit = `lfsr[0]`, taken before each shift.
    - The LFSR advances 8 steps per accepted byte; it does not advance on padding bytes.
    - The LFSR reseeds on reset and on every emit that followed a flush (frame boundary).
  - **Undefined:** bytes are packed unchanged; no LFSR logic is present.

## Test plan
- 16 bytes 0x00..0x0F back-to-back, `reader_en=1` → exactly one `valid_o` pulse 2 cycles after the 16th-byte edge. `reader_data=128'h0F0E0D0C0B0A09080706050403020100`.
- Backpressure: 16 bytes with `reader_en=0`.
  - `din_ready=0` and `fill_level=16`; no `valid_o` for 50 cycles.
  - Raise `reader_en` → pulse on the next cycle.
  - After the emit: `din_ready=1`, `fill_level=0`.
- Flush: bytes AA, BB, CC, with `flush` asserted in the same cycle as CC → `reader_data=128'h000000000000000000000000_00CCBBAA`, a single pulse.
- Reset and ignored flush:
  - `RST` after 7 bytes → `fill_level=0`, no pulse.
  - The next 16 bytes of 0x55 → word of all 0x55.
  - `flush` at `fill_level=0` → no pulse.
- `ce` toggling 1/0 every cycle during a 16-byte fill → word is identical to the `ce=1` case; bytes offered while `ce=0` are not consumed.
- With `BIT_PACKER_SCRAMBLE_EN`: 16 zero bytes → byte 0 of `reader_data` is 0xFF; bits [127:0] match the first 128 PN9 bits from seed 1FF. Flush, then 16 zero bytes → the same word is repeated (reseed).
